mdu_ctrl: RTL and testbench

- Multiply/divide unit sequencer for the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu issued from E stage over a fixed multi-cycle latency and owns the HI/LO registers.
- Services mthi/mtlo writes.
- Generates the D-stage stall for any HI/LO-related instruction while an operation is in flight.

---
 rtl/mdu_pkg.sv | 15 +
 rtl/mdu_arith.sv | 36 +++
 rtl/mdu_ctrl.sv | 79 +++++++
 tb/tb_mdu_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and default latencies for the MIPS multiply/divide unit
package mdu_pkg;
  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} mdu_state_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit {hi,lo} result for mult/multu/div/divu
//   i_op       op code (mdu_pkg encoding)
//   i_a, i_b   rs / rt operands
//   o_res      {hi,lo}: product, or {remainder,quotient} for divides
//   o_div_zero divide op with zero divisor (result must not be committed)
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_res,
  output logic        o_div_zero
);
  logic [63:0] w_smul, w_umul;
  logic [31:0] w_amag, w_bmag, w_sq_mag, w_sr_mag, w_sq, w_sr, w_uq, w_ur;
  logic        w_bz;
  assign w_bz     = i_b == 32'd0;
  assign w_smul   = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_umul   = {32'd0, i_a} * {32'd0, i_b};
  // Signed divide on magnitudes: avoids the INT_MIN/-1 overflow corner and
  // naturally yields truncation toward zero with remainder signed like the dividend.
  assign w_amag   = i_a[31] ? -i_a : i_a;
  assign w_bmag   = i_b[31] ? -i_b : i_b;
  assign w_sq_mag = w_bz ? 32'd0 : w_amag / w_bmag;
  assign w_sr_mag = w_bz ? 32'd0 : w_amag % w_bmag;
  assign w_sq     = (i_a[31] ^ i_b[31]) ? -w_sq_mag : w_sq_mag;
  assign w_sr     = i_a[31] ? -w_sr_mag : w_sr_mag;
  assign w_uq     = w_bz ? 32'd0 : i_a / i_b;
  assign w_ur     = w_bz ? 32'd0 : i_a % i_b;
  assign o_res    = i_op == MDU_MULT  ? w_smul :
                    i_op == MDU_MULTU ? w_umul :
                    i_op == MDU_DIV   ? {w_sr, w_sq} :
                    i_op == MDU_DIVU  ? {w_ur, w_uq} : 64'd0;
  assign o_div_zero = (i_op == MDU_DIV || i_op == MDU_DIVU) && w_bz;
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle mult/div sequencer owning HI/LO, with D-stage hazard stall
//   clk, rst_n        clock, async active-low reset
//   op_valid, mdu_op  E-stage MDU op and code
//   src_a, src_b      forwarded rs / rt
//   d_mdu_use         D-stage instruction touches the MDU or HI/LO
//   busy, stall       op in flight; freeze F/D
//   hi, lo            architectural HI/LO
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_mdu_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  mdu_state_e  r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic        r_pend_dz;
  logic [63:0] w_res;
  logic        w_dz, w_is_div, w_start, w_commit, w_idle_op;
  mdu_arith u_arith (
    .i_op      (mdu_op),
    .i_a       (src_a),
    .i_b       (src_b),
    .o_res     (w_res),
    .o_div_zero(w_dz)
  );
  assign busy      = r_state == S_RUN;
  assign w_idle_op = op_valid & ~busy;
  assign w_is_div  = mdu_op == MDU_DIV || mdu_op == MDU_DIVU;
  assign w_start   = w_idle_op & (mdu_op == MDU_MULT || mdu_op == MDU_MULTU || w_is_div);
  assign w_commit  = busy && r_cnt == CW'(1);
  assign stall     = d_mdu_use & (w_start | busy);
  assign hi        = r_hi;
  assign lo        = r_lo;
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE ? (w_start ? S_RUN : S_IDLE) : (w_commit ? S_IDLE : S_RUN);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_dz <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        {r_pend_hi, r_pend_lo} <= w_res;
        r_pend_dz <= w_dz;
        r_cnt     <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (busy) begin
        r_cnt <= r_cnt - CW'(1);
      end
      // A divide by zero runs its full busy period but leaves HI/LO untouched.
      if (w_commit && !r_pend_dz) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (w_idle_op && mdu_op == MDU_MTHI) r_hi <= src_a;
      if (w_idle_op && mdu_op == MDU_MTLO) r_lo <= src_a;
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl
module tb_mdu_ctrl;
  import mdu_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, op_valid = 1'b0, d_mdu_use = 1'b0;
  logic [2:0]  mdu_op = 3'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, stall;
  logic [31:0] hi, lo;
  int errors = 0, checks = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .mdu_op(mdu_op),
    .src_a(src_a), .src_b(src_b), .d_mdu_use(d_mdu_use),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; mdu_op = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0; mdu_op = MDU_NONE;
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (busy && k < 50) begin k++; @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    d_mdu_use = 1'b1;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    d_mdu_use = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_arith(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int n, input logic [31:0] ehi, input logic [31:0] elo);
    int k;
    drive(op, a, b);
    wait_idle(k);
    checks++; if (k !== n) begin errors++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", nm, k, n); end
    checks++; if (hi !== ehi) begin errors++; $display("FAIL %s_hi got=%h exp=%h", nm, hi, ehi); end
    checks++; if (lo !== elo) begin errors++; $display("FAIL %s_lo got=%h exp=%h", nm, lo, elo); end
  endtask

  task automatic test_mt_divzero;
    int k;
    drive(MDU_MTHI, 32'hDEADBEEF, 32'd0);
    checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi_hi got=%h exp=deadbeef", hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b exp=0", busy); end
    drive(MDU_MTHI, 32'h11, 32'd0);
    drive(MDU_MTLO, 32'h22, 32'd0);
    checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL mt_pair got=%h/%h exp=11/22", hi, lo); end
    drive(MDU_DIVU, 32'd7, 32'd0);
    wait_idle(k);
    checks++; if (k !== 10) begin errors++; $display("FAIL divzero_busy got=%0d exp=10", k); end
    checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL divzero_hilo got=%h/%h exp=11/22", hi, lo); end
    drive(3'd7, 32'h55, 32'h66);
    drive(MDU_NONE, 32'h55, 32'h66);
    checks++; if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
      errors++; $display("FAIL unused_op got=%b %h/%h exp=0 11/22", busy, hi, lo); end
  endtask

  task automatic test_hazard;
    int k;
    d_mdu_use = 1'b1;
    op_valid = 1'b1; mdu_op = MDU_DIV; src_a = 32'd100; src_b = 32'd7;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hazard_stall_T got=%b exp=1", stall); end
    @(posedge clk); #1;
    op_valid = 1'b0; mdu_op = MDU_NONE;
    for (int i = 1; i <= 10; i++) begin
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hazard_stall_T+%0d got=%b exp=1", i, stall); end
      @(posedge clk); #1;
    end
    checks++; if (stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hazard_release got=%b/%b exp=0/0", stall, busy); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL hazard_mflo got=%h/%h exp=2/e", hi, lo); end
    d_mdu_use = 1'b0;
    drive(MDU_MULTU, 32'd2, 32'd3);
    checks++; if (busy !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL nouse_stall got=%b/%b exp=1/0", busy, stall); end
    wait_idle(k);
  endtask

  task automatic test_ignore_busy;
    int k;
    drive(MDU_MULT, 32'd3, 32'd4);
    drive(MDU_MULT, 32'd5, 32'd6);
    drive(MDU_MTHI, 32'h99, 32'd0);
    wait_idle(k);
    checks++; if (k !== 3) begin errors++; $display("FAIL ignore_busy_cycles got=%0d exp=3", k); end
    checks++; if (hi !== 32'd0 || lo !== 32'd12) begin errors++; $display("FAIL ignore_hilo got=%h/%h exp=0/c", hi, lo); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_restart got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    drive(MDU_MTLO, 32'h77, 32'd0);
    drive(MDU_DIV, 32'd50, 32'd3);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midreset_hilo got=%h/%h exp=0/0", hi, lo); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_arith("post_reset_mult", MDU_MULT, 32'd6, 32'd7, 5, 32'd0, 32'd42);
  endtask

  initial begin
    test_reset;
    test_arith("mult",  MDU_MULT,  32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    test_arith("multu", MDU_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    test_arith("div",   MDU_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    test_arith("divu",  MDU_DIVU,  32'd7, 32'd2, 10, 32'd1, 32'd3);
    test_arith("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
    test_arith("div_neg", MDU_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);
    test_mt_divzero;
    test_hazard;
    test_ignore_busy;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
